cpu_controller: RTL and testbench

//   Eight-phase sequencer for the VeriRISC core. Drives the program counter (inc_pc, ld_pc), the

---
 rtl/cpu_controller.sv | 119 +++++++++++
 tb/tb_cpu_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// VeriRISC eight-phase control sequencer.
// Decodes IR opcode and ALU zero flag into PC, IR, ACC and memory strobes.
module cpu_controller #(
    parameter bit HALT_FREEZE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       halt,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    phase_t state;
    phase_t state_nxt;
    logic   halted;
    logic   halted_nxt;
    logic   is_hlt;
    logic   aluop;
    logic   freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
        end
    end

    always_comb begin
        is_hlt = (opcode == HLT);
        aluop  = (opcode == ADD) || (opcode == AND) ||
                 (opcode == XOR) || (opcode == LDA);
        // Entering or sitting in a halt parks the sequencer on OP_ADDR
        freeze = HALT_FREEZE &&
                 (halted || ((state == OP_ADDR) && is_hlt));
        halted_nxt = freeze;
        state_nxt  = freeze ? OP_ADDR : phase_t'(state + 3'd1);
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        unique case (state)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                halt   = is_hlt || halted;
                inc_pc = !(is_hlt || halted);
            end
            OP_FETCH: begin
                rd = aluop;
            end
            ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == SKZ) && zero;
                ld_pc  = (opcode == JMP);
                data_e = (opcode == STO);
            end
            STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = (opcode == JMP);
                wr     = (opcode == STO);
                data_e = (opcode == STO);
            end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: random instruction stream vs.
// a phase-rule reference model, plus a PC model fed by the strobes.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, halt;
    logic       data_e, ld_ac, wr;
    logic [2:0] phase;

    cpu_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .halt(halt), .data_e(data_e),
        .ld_ac(ld_ac), .wr(wr), .phase(phase)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [11:0] exp_q[$];
    logic [4:0]  pc_q[$];

    int         m_phase;
    bit         m_halted;
    logic [4:0] ir_addr;
    logic [4:0] pc_exp;
    logic [4:0] pc;

    // Program counter driven only by the controller's strobes
    always @(posedge clk) begin
        if (rst) pc <= 5'd0;
        else if (ld_pc) pc <= ir_addr;
        else if (inc_pc) pc <= pc + 5'd1;
    end

    // Expected output vector for one cycle, written from the phase rules
    function automatic logic [11:0] model(int ph, logic [2:0] op,
                                          logic z, bit hlt);
        bit aluop, halting;
        bit e_sel, e_rd, e_ldir, e_inc, e_ldpc;
        bit e_halt, e_de, e_ldac, e_wr;
        aluop   = (op >= 3'd2) && (op <= 3'd5);
        halting = (ph == 4) && ((op == 3'd0) || hlt);
        e_sel   = (ph <= 3);
        e_rd    = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
        e_ldir  = (ph == 2) || (ph == 3);
        e_inc   = ((ph == 4) && !halting) ||
                  ((ph == 6) && (op == 3'd1) && z);
        e_ldpc  = (ph >= 6) && (op == 3'd7);
        e_halt  = halting;
        e_de    = (ph >= 6) && (op == 3'd6);
        e_ldac  = (ph == 7) && aluop;
        e_wr    = (ph == 7) && (op == 3'd6);
        return {3'(ph), e_sel, e_rd, e_ldir, e_inc, e_ldpc,
                e_halt, e_de, e_ldac, e_wr};
    endfunction

    // Monitor: pops one expectation per cycle, away from the active edge
    always @(negedge clk) begin
        logic [11:0] act;
        logic [11:0] e;
        logic [4:0]  pe;
        act = {phase, sel, rd, ld_ir, inc_pc, ld_pc,
               halt, data_e, ld_ac, wr};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (act !== e) begin
                mismatched++;
                $display("FAIL outputs: got %h expected %h (t=%0t)",
                         act, e, $time);
            end
        end
        if (pc_q.size() > 0 && phase == 3'd0) begin
            pe = pc_q.pop_front();
            compared++;
            if (pc !== pe) begin
                mismatched++;
                $display("FAIL pc: got %h expected %h (t=%0t)",
                         pc, pe, $time);
            end
        end
    end

    // One clock of stimulus; opcode/zero are noise where they must not matter
    task automatic step(input logic [2:0] op, input logic z);
        opcode = (m_phase <= 2) ? 3'($urandom_range(0, 7)) : op;
        zero   = (m_phase == 6) ? z : 1'($urandom_range(0, 1));
        exp_q.push_back(model(m_phase, op, z, m_halted));
        @(posedge clk);
        #1;
        if (m_halted || (m_phase == 4 && op == 3'd0)) begin
            m_halted = 1'b1;
            m_phase  = 4;
        end else begin
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic instr(input logic [2:0] op, input logic z,
                         input logic [4:0] addr);
        ir_addr = addr;
        for (int i = 0; i < 8; i++) step(op, z);
        if (op == 3'd7) pc_exp = addr;
        else pc_exp = pc_exp + 5'd1 + ((op == 3'd1 && z) ? 5'd1 : 5'd0);
        pc_q.push_back(pc_exp);
    endtask

    initial begin
        rst      = 1'b1;
        opcode   = 3'd0;
        zero     = 1'b0;
        ir_addr  = 5'd0;
        pc_exp   = 5'd0;
        m_phase  = 0;
        m_halted = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(0, 3'd0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        instr(3'd2, 1'b0, 5'h03);
        instr(3'd1, 1'b1, 5'h04);
        instr(3'd1, 1'b0, 5'h05);
        instr(3'd7, 1'b0, 5'h1A);
        instr(3'd6, 1'b0, 5'h07);
        for (int n = 0; n < 60; n++)
            instr(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom));

        // Halt and stay parked for 20 more clocks
        ir_addr = 5'h11;
        for (int i = 0; i < 25; i++) step(3'd0, 1'b0);

        // Synchronous reset: takes effect at the following edge
        rst = 1'b1;
        exp_q.push_back(model(m_phase, 3'd0, 1'b0, m_halted));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_phase  = 0;
        m_halted = 1'b0;
        pc_exp   = 5'd0;
        instr(3'd2, 1'b0, 5'h09);
        instr(3'd7, 1'b1, 5'h1A);

        // Bounded drain of any outstanding expectations
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && pc_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0 || pc_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d outputs, %0d pcs left, need 0",
                     exp_q.size(), pc_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
